// File: rtl/mat_mult_seq_if.sv
// Operand/result bundle and start/busy/done handshake for the sequential matrix multiplier.
// The driver owns start and the operand buses; the multiplier owns busy, done and the result bus.
interface mat_mult_seq_if #(
    parameter int DAT_W = 8,
    parameter int MAT_N = 2,
    parameter int ACC_W = 2 * DAT_W + $clog2(MAT_N)
);
    logic                           start;
    logic [MAT_N*MAT_N*DAT_W-1:0]   mat_a;
    logic [MAT_N*MAT_N*DAT_W-1:0]   mat_b;
    logic                           busy;
    logic                           done;
    logic [MAT_N*MAT_N*ACC_W-1:0]   mat_c;

    modport master (output start, mat_a, mat_b, input busy, done, mat_c);
    modport slave  (input start, mat_a, mat_b, output busy, done, mat_c);
endinterface

// File: rtl/mat_mult_seq.sv
// Sequential C = A x B for square MAT_N x MAT_N operands, LANES shared MAC units.
// Each lane owns one result element per group and spends MAT_N cycles accumulating it.
module mat_mult_seq #(
    parameter int DAT_W  = 8,
    parameter int MAT_N  = 2,
    parameter int LANES  = 1,
    parameter int SIGNED = 0,
    parameter int ACC_W  = 2 * DAT_W + $clog2(MAT_N)
) (
    input  logic           clk,
    input  logic           rst_n,
    mat_mult_seq_if.slave  bus
);
    localparam int NN    = MAT_N * MAT_N;
    localparam int G     = NN / LANES;
    localparam int IDX_W = $clog2(NN);
    localparam int K_W   = $clog2(MAT_N);
    localparam int GRP_W = (G > 1) ? $clog2(G) : 1;

    if (MAT_N < 2) begin : g_bad_n
        $error("mat_mult_seq: MAT_N must be at least 2");
    end
    if ((NN % LANES) != 0) begin : g_bad_lanes
        $error("mat_mult_seq: MAT_N*MAT_N must be a multiple of LANES");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state, state_nxt;
    logic [K_W-1:0]         k;
    logic [GRP_W-1:0]       grp;
    logic                   accept, last_k, last_grp;
    logic [DAT_W-1:0]       a_q   [NN];
    logic [DAT_W-1:0]       b_q   [NN];
    logic [ACC_W-1:0]       c_q   [NN];
    logic [ACC_W-1:0]       acc   [LANES];
    logic [ACC_W-1:0]       prod  [LANES];
    logic [IDX_W-1:0]       elem  [LANES];

    // Widen each operand by one bit carrying its sign (or zero), then resize the
    // exact product to ACC_W; the result always fits, so nothing saturates or wraps.
    function automatic logic [ACC_W-1:0] mac_prod(input logic [DAT_W-1:0] x,
                                                  input logic [DAT_W-1:0] y);
        logic signed [DAT_W:0]     xs, ys;
        logic signed [2*DAT_W+1:0] p;
        xs = {(SIGNED != 0) && x[DAT_W-1], x};
        ys = {(SIGNED != 0) && y[DAT_W-1], y};
        p  = (2*DAT_W+2)'(xs) * (2*DAT_W+2)'(ys);
        return ACC_W'(p);
    endfunction

    assign accept   = bus.start && (state == IDLE || state == DONE);
    assign last_k   = (k == K_W'(MAT_N - 1));
    assign last_grp = (grp == GRP_W'(G - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last_k && last_grp) state_nxt = DONE;
            DONE:    state_nxt = accept ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        int e, r, c;
        assign e       = int'(grp) * LANES + l;
        assign r       = e / MAT_N;
        assign c       = e % MAT_N;
        assign elem[l] = IDX_W'(e);
        assign prod[l] = mac_prod(a_q[IDX_W'(r * MAT_N + int'(k))],
                                  b_q[IDX_W'(int'(k) * MAT_N + c)]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k   <= '0;
            grp <= '0;
            for (int i = 0; i < NN; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
                c_q[i] <= '0;
            end
            for (int l = 0; l < LANES; l++) acc[l] <= '0;
        end else if (accept) begin
            k   <= '0;
            grp <= '0;
            for (int i = 0; i < NN; i++) begin
                a_q[i] <= bus.mat_a[i*DAT_W +: DAT_W];
                b_q[i] <= bus.mat_b[i*DAT_W +: DAT_W];
                c_q[i] <= '0;
            end
            for (int l = 0; l < LANES; l++) acc[l] <= '0;
        end else if (state == RUN) begin
            k <= last_k ? '0 : k + K_W'(1);
            if (last_k) grp <= last_grp ? '0 : grp + GRP_W'(1);
            // Final k: the completed sum goes straight to the result, lane restarts at zero.
            for (int l = 0; l < LANES; l++) begin
                if (last_k) begin
                    c_q[elem[l]] <= acc[l] + prod[l];
                    acc[l]       <= '0;
                end else begin
                    acc[l] <= acc[l] + prod[l];
                end
            end
        end
    end

    for (genvar i = 0; i < NN; i++) begin : g_pack
        assign bus.mat_c[i*ACC_W +: ACC_W] = c_q[i];
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
endmodule

// File: tb/tb_mat_mult_seq.sv
// Bench for mat_mult_seq: three configurations driven one at a time, results checked
// by per-instance monitors against an integer matrix-product model.
module tb_mat_mult_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mat_mult_seq_if #(.DAT_W(8), .MAT_N(2), .ACC_W(17)) if0 ();
    mat_mult_seq_if #(.DAT_W(8), .MAT_N(2), .ACC_W(17)) if1 ();
    mat_mult_seq_if #(.DAT_W(8), .MAT_N(4), .ACC_W(18)) if2 ();

    mat_mult_seq #(.DAT_W(8), .MAT_N(2), .LANES(1), .SIGNED(0), .ACC_W(17))
        u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    mat_mult_seq #(.DAT_W(8), .MAT_N(2), .LANES(2), .SIGNED(1), .ACC_W(17))
        u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    mat_mult_seq #(.DAT_W(8), .MAT_N(4), .LANES(4), .SIGNED(0), .ACC_W(18))
        u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    logic [511:0] q0[$];
    logic [511:0] q1[$];
    logic [511:0] q2[$];

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic longint elem(input logic [127:0] v, input int idx, input bit sgn);
        logic [7:0] b8;
        b8 = v[idx*8 +: 8];
        return sgn ? longint'($signed(b8)) : longint'(b8);
    endfunction

    // Plain C[r][c] = sum_k A[r][k]*B[k][c], packed at ACC width.
    function automatic logic [511:0] ref_mm(input logic [127:0] a, input logic [127:0] b,
                                            input int n, input bit sgn, input int accw);
        logic [511:0] res;
        logic [63:0]  u;
        longint       s;
        res = '0;
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                s = 0;
                for (int k = 0; k < n; k++) s += elem(a, r*n+k, sgn) * elem(b, k*n+c, sgn);
                u = 64'(s) & ((64'd1 << accw) - 64'd1);
                res |= 512'(u) << ((r*n+c)*accw);
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic set_start(input int d, input logic v);
        case (d)
            0: if0.start = v;
            1: if1.start = v;
            default: if2.start = v;
        endcase
    endtask

    task automatic set_ops(input int d, input logic [127:0] a, input logic [127:0] b);
        case (d)
            0: begin if0.mat_a = a[31:0]; if0.mat_b = b[31:0]; end
            1: begin if1.mat_a = a[31:0]; if1.mat_b = b[31:0]; end
            default: begin if2.mat_a = a; if2.mat_b = b; end
        endcase
    endtask

    task automatic push_exp(input int d, input logic [127:0] a, input logic [127:0] b);
        case (d)
            0: q0.push_back(ref_mm(a, b, 2, 1'b0, 17));
            1: q1.push_back(ref_mm(a, b, 2, 1'b1, 17));
            default: q2.push_back(ref_mm(a, b, 4, 1'b0, 18));
        endcase
    endtask

    function automatic logic get_done(input int d);
        return (d == 0) ? if0.done : (d == 1) ? if1.done : if2.done;
    endfunction

    function automatic logic get_busy(input int d);
        return (d == 0) ? if0.busy : (d == 1) ? if1.busy : if2.busy;
    endfunction

    function automatic logic [511:0] get_c(input int d);
        return (d == 0) ? 512'(if0.mat_c) : (d == 1) ? 512'(if1.mat_c) : 512'(if2.mat_c);
    endfunction

    // Called at a negedge; that cycle is T0. Returns at the negedge of the done cycle.
    task automatic run_job(input int d, input logic [127:0] a, input logic [127:0] b,
                           input bit hold);
        int gn, lat;
        gn  = (d == 0) ? 8 : (d == 1) ? 4 : 16;
        lat = 0;
        set_ops(d, a, b);
        set_start(d, 1'b1);
        push_exp(d, a, b);
        for (int i = 1; i <= gn + 4; i++) begin
            @(negedge clk);
            if (i == 1 && !hold) set_start(d, 1'b0);
            if (i == 3) set_ops(d, rnd128(), rnd128());
            if (get_done(d)) begin
                lat = i;
                break;
            end
            check($sformatf("d%0d busy T%0d", d, i), 512'(get_busy(d)), 512'(1));
        end
        check($sformatf("d%0d done latency", d), 512'(lat), 512'(gn + 1));
        check($sformatf("d%0d busy at done", d), 512'(get_busy(d)), 512'(0));
        set_start(d, 1'b0);
    endtask

    always @(negedge clk) begin
        if (if0.done === 1'b1) begin
            if (q0.size() == 0) check("d0 unexpected done", 512'(1), 512'(0));
            else check("d0 result", 512'(if0.mat_c), q0.pop_front());
        end
        if (if1.done === 1'b1) begin
            if (q1.size() == 0) check("d1 unexpected done", 512'(1), 512'(0));
            else check("d1 result", 512'(if1.mat_c), q1.pop_front());
        end
        if (if2.done === 1'b1) begin
            if (q2.size() == 0) check("d2 unexpected done", 512'(1), 512'(0));
            else check("d2 result", 512'(if2.mat_c), q2.pop_front());
        end
    end

    initial begin
        logic [127:0] a, b;
        logic [511:0] exp;

        for (int d = 0; d < 3; d++) begin
            set_start(d, 1'b0);
            set_ops(d, '0, '0);
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("d%0d reset busy", d), 512'(get_busy(d)), 512'(0));
            check($sformatf("d%0d reset done", d), 512'(get_done(d)), 512'(0));
            check($sformatf("d%0d reset C", d), get_c(d), 512'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Worked example
        run_job(0, 128'h04030201, 128'h08070605, 1'b0);
        check("d0 example C", get_c(0), 512'({17'd50, 17'd43, 17'd22, 17'd19}));
        repeat (2) @(negedge clk);

        // Largest unsigned operands
        run_job(0, 128'hFFFFFFFF, 128'hFFFFFFFF, 1'b0);
        check("d0 all-255 C", get_c(0), 512'({4{17'd130050}}));
        repeat (2) @(negedge clk);

        // Identity B returns A zero-extended
        a = rnd128();
        run_job(0, a, 128'h01000001, 1'b0);
        exp = '0;
        for (int e = 0; e < 4; e++) exp[e*17 +: 17] = 17'(a[e*8 +: 8]);
        check("d0 identity C", get_c(0), exp);
        repeat (2) @(negedge clk);

        // Signed corner and sign extension
        run_job(1, 128'h80808080, 128'h80808080, 1'b0);
        check("d1 all-neg128 C", get_c(1), 512'({4{17'd32768}}));
        repeat (2) @(negedge clk);
        run_job(1, 128'hFC0302FF, 128'h01000001, 1'b0);
        check("d1 signed identity C", get_c(1), 512'({17'h1FFFC, 17'd3, 17'd2, 17'h1FFFF}));
        repeat (2) @(negedge clk);

        // start held through the run; operands swapped at T3
        run_job(0, rnd128(), rnd128(), 1'b1);
        repeat (4) @(negedge clk);

        // Reset in the middle of a job
        set_ops(0, 128'h04030201, 128'h08070605);
        set_start(0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) set_start(0, 1'b0);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("d0 abort busy", 512'(if0.busy), 512'(0));
        check("d0 abort done", 512'(if0.done), 512'(0));
        check("d0 abort C", 512'(if0.mat_c), 512'(0));
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        run_job(0, rnd128(), rnd128(), 1'b0);
        repeat (2) @(negedge clk);

        // Back-to-back jobs restarted in the DONE cycle
        for (int j = 0; j < 4; j++) run_job(2, rnd128(), rnd128(), 1'b0);
        repeat (2) @(negedge clk);
        for (int j = 0; j < 3; j++) run_job(1, rnd128(), rnd128(), 1'b0);
        repeat (2) @(negedge clk);
        for (int j = 0; j < 3; j++) run_job(0, rnd128(), rnd128(), 1'b0);
        repeat (4) @(negedge clk);

        check("d0 results drained", 512'(q0.size()), 512'(0));
        check("d1 results drained", 512'(q1.size()), 512'(0));
        check("d2 results drained", 512'(q2.size()), 512'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
